// File: rtl/vita_pkg.sv
// Shared VITA2000 definitions: sync-channel codes, transmitter state encoding and the
// byte-wide CRC-8 step (poly 0x07, MSB-first) used on the data channels.
package vita_pkg;

  localparam logic [7:0] SYNC_FS  = 8'h5A;
  localparam logic [7:0] SYNC_LS  = 8'h2A;
  localparam logic [7:0] SYNC_FE  = 8'h6A;
  localparam logic [7:0] SYNC_LE  = 8'h3A;
  localparam logic [7:0] SYNC_IMG = 8'h0D;
  localparam logic [7:0] SYNC_BL  = 8'h15;
  localparam logic [7:0] SYNC_CRC = 8'h59;
  localparam logic [7:0] SYNC_TP  = 8'hE9;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOL  = 3'd1,
    ST_IMG  = 3'd2,
    ST_EOL  = 3'd3,
    ST_CRC  = 3'd4,
    ST_HBL  = 3'd5,
    ST_VBL  = 3'd6
  } tx_state_t;

  // Absorb one data byte into the running CRC, most significant bit first.
  function automatic logic [7:0] vita_crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vita_crc8_lane.sv
// One data channel's CRC-8 accumulator: reloads on init, absorbs one byte per enabled cycle.
import vita_pkg::*;

module vita_crc8_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // CRC register: init has priority so a line always starts from the seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (init) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= vita_crc8_next(crc, data);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/vita_frame_tx.sv
// VITA2000 parallel-side frame generator (sync word + 4 data channels per par_clock).
// Optional per-channel line CRC when VITA_FRAME_TX_CRC_EN is defined.
import vita_pkg::*;

module vita_frame_tx #(
  parameter int KERNELS    = 240,
  parameter int LINES      = 1080,
  parameter int HBLANK     = 16,
  parameter int VBLANK     = 64,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic        par_clock,
  input  logic        par_reset_n,
  input  logic        start,
  output logic [7:0]  sync,
  output logic [31:0] cam_d,
  output logic        busy,
  output logic        frame_done
);

  localparam int KW   = (KERNELS > 1) ? $clog2(KERNELS) : 1;
  localparam int LW   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [KW-1:0] KERN_LAST = KW'(KERNELS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LAST   = BW'((VBLANK > 0) ? VBLANK - 1 : 0);
  localparam tx_state_t     FRAME_NEXT = CONTINUOUS ? ST_SOL : ST_IDLE;

  tx_state_t         state_r, state_s, after_line_s;
  logic [KW-1:0]     kern_r, kern_s;
  logic [LW-1:0]     line_r, line_s, line_adv_s;
  logic [BW-1:0]     blank_r, blank_s;
  logic              last_line_s, frame_end_s;
  logic [7:0]        sync_s;
  logic [31:0]       cam_s, img_s, crc_word_s;

  // Where the machine goes once a line's last cycle (CRC or final HBL) has been sent.
  always_comb begin
    last_line_s = (line_r == LINE_LAST);
    line_adv_s  = last_line_s ? '0 : line_r + LW'(1);
    if (!last_line_s) begin
      after_line_s = ST_SOL;
    end else if (VBLANK > 0) begin
      after_line_s = ST_VBL;
    end else begin
      after_line_s = FRAME_NEXT;
    end
  end

  // Next-state and counter logic; frame_end_s marks the cycle whose output is the last of the frame.
  always_comb begin
    state_s     = state_r;
    kern_s      = kern_r;
    line_s      = line_r;
    blank_s     = blank_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SOL;
          line_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SOL: begin
        state_s = ST_IMG;
        kern_s  = '0;
      end
      ST_IMG: begin
        if (kern_r == KERN_LAST) begin
          state_s = ST_EOL;
          kern_s  = '0;
        end else begin
          kern_s  = kern_r + KW'(1);
        end
      end
      ST_EOL: state_s = ST_CRC;
      ST_CRC: begin
        blank_s = '0;
        if (HBLANK > 0) begin
          state_s = ST_HBL;
        end else begin
          state_s     = after_line_s;
          line_s      = line_adv_s;
          frame_end_s = last_line_s && (VBLANK == 0);
        end
      end
      ST_HBL: begin
        if (blank_r == HB_LAST) begin
          state_s     = after_line_s;
          line_s      = line_adv_s;
          blank_s     = '0;
          frame_end_s = last_line_s && (VBLANK == 0);
        end else begin
          blank_s = blank_r + BW'(1);
        end
      end
      ST_VBL: begin
        if (blank_r == VB_LAST) begin
          state_s     = FRAME_NEXT;
          blank_s     = '0;
          frame_end_s = 1'b1;
        end else begin
          blank_s = blank_r + BW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        kern_s  = '0;
        line_s  = '0;
        blank_s = '0;
      end
    endcase
  end

  // Image byte for channel k is (line + 4*kernel + k) mod 256.
  always_comb begin
    img_s = '0;
    for (int k = 0; k < 4; k++) begin
      img_s[8*k +: 8] = 8'(line_r) + 8'({kern_r, 2'b00}) + 8'(k);
    end
  end

`ifdef VITA_FRAME_TX_CRC_EN
  for (genvar g = 0; g < 4; g++) begin : g_crc
    vita_crc8_lane u_lane (
      .clk   (par_clock),
      .rst_n (par_reset_n),
      .init  (state_r == ST_SOL),
      .en    (state_r == ST_IMG),
      .data  (img_s[8*g +: 8]),
      .crc   (crc_word_s[8*g +: 8])
    );
  end
`else
  assign crc_word_s = 32'h0000_0000;
`endif

  // Output word for the current state; registered below so outputs trail state by one cycle.
  always_comb begin
    sync_s = SYNC_TP;
    cam_s  = {4{SYNC_TP}};
    case (state_r)
      ST_IDLE: begin
        sync_s = SYNC_TP;
        cam_s  = {4{SYNC_TP}};
      end
      ST_SOL: begin
        sync_s = (line_r == '0) ? SYNC_FS : SYNC_LS;
        cam_s  = 32'h0000_0000;
      end
      ST_IMG: begin
        sync_s = SYNC_IMG;
        cam_s  = img_s;
      end
      ST_EOL: begin
        sync_s = last_line_s ? SYNC_FE : SYNC_LE;
        cam_s  = 32'h0000_0000;
      end
      ST_CRC: begin
        sync_s = SYNC_CRC;
        cam_s  = crc_word_s;
      end
      ST_HBL, ST_VBL: begin
        sync_s = SYNC_BL;
        cam_s  = 32'h0000_0000;
      end
      default: begin
        sync_s = SYNC_TP;
        cam_s  = {4{SYNC_TP}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge par_clock) begin
    if (!par_reset_n) begin
      state_r    <= ST_IDLE;
      kern_r     <= '0;
      line_r     <= '0;
      blank_r    <= '0;
      sync       <= SYNC_TP;
      cam_d      <= {4{SYNC_TP}};
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      kern_r     <= kern_s;
      line_r     <= line_s;
      blank_r    <= blank_s;
      sync       <= sync_s;
      cam_d      <= cam_s;
      busy       <= (state_r != ST_IDLE);
      frame_done <= frame_end_s;
    end
  end

endmodule
